wb_arbiter: RTL

Write-back arbiter and buffer that owns the register file's single write port (`we`/`waddr`/`wdata`). It merges single-cycle ALU results with variable-latency memory/load results, queues the memory results in a small FIFO, and issues at most one register write per cycle. It also exports a pending-destination mask so the decode stage can stall on registers with queued writes.

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_arbiter_fifo.sv | 106 ++++++++++
 rtl/wb_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file geometry and write-back defaults for wb_arbiter.
package wb_arbiter_pkg;

   localparam int RegBus     = 32;  // register data width
   localparam int RegAddrBus = 5;   // register address width
   localparam int RegNum     = 32;  // number of architectural registers
   localparam int WbQDepth   = 4;   // memory write FIFO depth

   // Source selected for this cycle's register-file write
   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_FIFO,
      SRC_BYP
   } wb_src_e;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: circular memory-result queue with per-entry valid bits.
// Entries whose destination is overwritten by a younger ALU write are
// invalidated in place; a pop skips over them to the first live entry
// in the same cycle, and a pop with no live entry flushes the dead ones.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus,
   parameter int QDEPTH = WbQDepth,
   localparam int PW    = $clog2(QDEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [ADDR_W-1:0]      push_addr_i,
   input  logic [DATA_W-1:0]      push_data_i,
   input  logic                   pop_i,
   input  logic                   inv_i,
   input  logic [ADDR_W-1:0]      inv_addr_i,
   output logic                   full_o,
   output logic                   any_valid_o,
   output logic [ADDR_W-1:0]      head_addr_o,
   output logic [DATA_W-1:0]      head_data_o,
   output logic [CW-1:0]          count_o,
   output logic [2**ADDR_W-1:0]   pend_mask_o
);

   logic [ADDR_W-1:0] addr_q [QDEPTH];
   logic [DATA_W-1:0] data_q [QDEPTH];
   logic [QDEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d, popn;
   logic [PW-1:0]     idx, hit_idx, hit_off;
   logic              found;

   // Locate the oldest live entry; valid bits outside the occupied window are always 0
   always_comb begin
      found   = 1'b0;
      hit_off = '0;
      hit_idx = rd_q;
      idx     = rd_q;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
         idx = rd_q + PW'(i);
         if (!found && vld_q[idx]) begin
            found   = 1'b1;
            hit_off = PW'(i);
            hit_idx = idx;
         end
      end
   end

   // Next-state for pointers, count and valid bits
   always_comb begin
      popn = '0;
      if (pop_i) popn = found ? CW'(hit_off) + CW'(1) : cnt_q;
      vld_d = vld_q;
      if (inv_i) begin
         for (int unsigned i = 0; i < QDEPTH; i++)
            if (vld_q[i] && addr_q[i] == inv_addr_i) vld_d[i] = 1'b0;
      end
      if (pop_i && found) vld_d[hit_idx] = 1'b0;
      if (push_i) vld_d[wr_q] = 1'b1;
      rd_d  = rd_q + PW'(popn);
      wr_d  = push_i ? wr_q + PW'(1) : wr_q;
      cnt_d = cnt_q + CW'(push_i) - popn;
   end

   // Pending-destination mask over live entries
   always_comb begin
      pend_mask_o = '0;
      for (int unsigned i = 0; i < QDEPTH; i++)
         if (vld_q[i]) pend_mask_o[addr_q[i]] = 1'b1;
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage, written on push
   always_ff @(posedge clk) begin
      if (push_i) begin
         addr_q[wr_q] <= push_addr_i;
         data_q[wr_q] <= push_data_i;
      end
   end

   assign full_o      = (cnt_q == CW'(QDEPTH));
   assign any_valid_o = found;
   assign head_addr_o = addr_q[hit_idx];
   assign head_data_o = data_q[hit_idx];
   assign count_o     = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the register-file write port, merging ALU results
// (highest priority) with queued memory results, one write per cycle.
// Optional feature macro: WB_BYPASS_EN lets a memory result into an idle
// arbiter go straight to the write port without occupying a FIFO slot.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus,
   parameter int QDEPTH = WbQDepth
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_waddr,
   input  logic [DATA_W-1:0]        alu_wdata,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_waddr,
   input  logic [DATA_W-1:0]        mem_wdata,
   output logic                     we,
   output logic [ADDR_W-1:0]        waddr,
   output logic [DATA_W-1:0]        wdata,
   output logic [2**ADDR_W-1:0]     pend_mask,
   output logic [$clog2(QDEPTH):0]  q_count
);

   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              alu_issue, mem_acc, q_full, q_any, q_push, q_pop;
   logic [ADDR_W-1:0] q_addr;
   logic [DATA_W-1:0] q_data;
   wb_src_e           src;

   assign alu_issue = alu_valid && (alu_waddr != '0);
   assign mem_ready = rst && !q_full;
   // x0 results are consumed here and never reach the queue
   assign mem_acc   = mem_valid && mem_ready && (mem_waddr != '0);
   assign q_push    = mem_acc && (src != SRC_BYP);
   assign q_pop     = !alu_issue && (q_count != '0);

   wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (q_push),
      .push_addr_i (mem_waddr),
      .push_data_i (mem_wdata),
      .pop_i       (q_pop),
      .inv_i       (alu_issue),
      .inv_addr_i  (alu_waddr),
      .full_o      (q_full),
      .any_valid_o (q_any),
      .head_addr_o (q_addr),
      .head_data_o (q_data),
      .count_o     (q_count),
      .pend_mask_o (pend_mask)
   );

   // Priority select: ALU, then oldest live queue entry, then optional bypass
   always_comb begin
      src     = SRC_NONE;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (alu_issue) begin
         src = SRC_ALU;
      end else if (q_any) begin
         src = SRC_FIFO;
      end
`ifdef WB_BYPASS_EN
      else if (mem_acc) begin
         src = SRC_BYP;
      end
`endif
      case (src)
         SRC_ALU:  begin we_d = 1'b1; waddr_d = alu_waddr; wdata_d = alu_wdata; end
         SRC_FIFO: begin we_d = 1'b1; waddr_d = q_addr;    wdata_d = q_data;    end
         SRC_BYP:  begin we_d = 1'b1; waddr_d = mem_waddr; wdata_d = mem_wdata; end
         default:  ;
      endcase
   end

   // Registered write port
   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign we    = we_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;

endmodule
